// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU.
// On an accepted start it latches the operand magnitudes and produces one
// quotient bit per clock. It then presents {remainder, quotient} with a
// one-cycle valid pulse. stall_o holds the upstream pipeline while a result
// is pending. It drops in the DONE cycle so the result is captured as the
// pipeline advances.
//
// Handshake: a request is accepted only when the FSM is IDLE, start_i is high
// and cancel_i is low at a rising edge. There is no ready signal. Upstream
// must keep the instruction in place while stall_o is high. A start that
// arrives while BUSY or DONE is dropped, not queued. valid_o is a one-cycle
// pulse with no back-pressure, so the consumer must capture result_o in that
// cycle. result_o then stays stable until the next completed division.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start_i,
  input  logic                 signed_i,
  input  logic                 cancel_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic                 stall_o,
  output logic                 valid_o,
  output logic [2*WIDTH-1:0]   result_o,
  output logic [1:0]           state_dbg
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem_q;     // partial remainder (always < divisor)
  logic [WIDTH-1:0] quo_q;     // dividend bits shifting out, quotient bits in
  logic [WIDTH-1:0] div_q;     // divisor magnitude
  logic             neg_quo;
  logic             neg_rem;
  logic             valid_r;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;
  logic [WIDTH-1:0] rem_fix;
  logic [WIDTH-1:0] quo_fix;

  // Operand magnitudes at start. The most negative value maps onto its own
  // unsigned magnitude, which the unsigned core handles correctly.
  always_comb begin
    a_neg = signed_i & a_i[WIDTH-1];
    b_neg = signed_i & b_i[WIDTH-1];
    a_mag = a_neg ? (~a_i + 1'b1) : a_i;
    b_mag = b_neg ? (~b_i + 1'b1) : b_i;
  end

  // One restoring step on a WIDTH+1-bit partial remainder, plus sign fix-up
  // of the values produced by the final step.
  always_comb begin
    trial   = {rem_q, quo_q[WIDTH-1]};
    diff    = trial - {1'b0, div_q};
    rem_nxt = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
    quo_nxt = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
    rem_fix = neg_rem ? (~rem_nxt + 1'b1) : rem_nxt;
    quo_fix = neg_quo ? (~quo_nxt + 1'b1) : quo_nxt;
  end

  // Pipeline hold is needed from the accepting cycle through the last
  // iteration.
  always_comb begin
    stall_o   = ((state == IDLE) & start_i & ~cancel_i) | (state == BUSY);
    valid_o   = valid_r & ~cancel_i;
    state_dbg = state;
  end

  // Control FSM and datapath. Cancel aborts from any state without touching
  // result_o.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      cnt      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      div_q    <= '0;
      neg_quo  <= 1'b0;
      neg_rem  <= 1'b0;
      valid_r  <= 1'b0;
      result_o <= '0;
    end else begin
      valid_r <= 1'b0;
      if (cancel_i) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start_i) begin
              rem_q   <= '0;
              quo_q   <= a_mag;
              div_q   <= b_mag;
              neg_quo <= a_neg ^ b_neg;
              neg_rem <= a_neg;
              cnt     <= '0;
              if (b_i == '0) begin
                state    <= DONE;
                result_o <= '0;
                valid_r  <= 1'b1;
              end else begin
                state <= BUSY;
              end
            end
          end
          BUSY: begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
            cnt   <= cnt + 1'b1;
            if (cnt == CW'(WIDTH - 1)) begin
              state    <= DONE;
              cnt      <= '0;
              result_o <= {rem_fix, quo_fix};
              valid_r  <= 1'b1;
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases, randomized
// operands, cancel, ignored restart and asynchronous reset mid-operation.
module tb_div_unit;

  logic        clk;
  logic        resetn;
  logic        start_i;
  logic        signed_i;
  logic        cancel_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        stall_o;
  logic        valid_o;
  logic [63:0] result_o;
  logic [1:0]  state_dbg;

  int checks   = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  div_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start_i   (start_i),
    .signed_i  (signed_i),
    .cancel_i  (cancel_i),
    .a_i       (a_i),
    .b_i       (b_i),
    .stall_o   (stall_o),
    .valid_o   (valid_o),
    .result_o  (result_o),
    .state_dbg (state_dbg)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model. Signed operands are sign-extended into 64-bit integers,
  // whose truncating division gives the architected quotient and remainder.
  // The overflow case 0x80000000 / -1 yields +2^31, which truncates to
  // 0x80000000.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
    end else begin
      sa = {32'd0, a};
      sb = {32'd0, b};
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Monitor: every valid pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (valid_o) begin
      if (exp_q.size() == 0) chk("unexpected_valid", 64'd1, 64'd0);
      else chk("result", result_o, exp_q.pop_front());
    end
  end

  // Driver: issue one divide, then check stall/latency/pulse/hold timing.
  // With poke set, a second start with other operands is pulsed mid-operation.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input bit poke);
    logic [63:0] exp;
    int n, st;
    bit seen;
    logic stall_at_valid;
    exp = ref_div(a, b, s);
    @(negedge clk);
    a_i = a; b_i = b; signed_i = s; start_i = 1'b1;
    #1 chk("stall_start", {63'd0, stall_o}, 64'd1);
    exp_q.push_back(exp);
    @(posedge clk);
    #1 start_i = 1'b0;
    a_i = $urandom; b_i = $urandom; signed_i = ~s;
    n = 0; st = 0; seen = 0; stall_at_valid = 1'b0;
    while (n < 100 && !seen) begin
      @(negedge clk);
      n++;
      if (valid_o) begin
        seen = 1;
        stall_at_valid = stall_o;
      end else begin
        if (stall_o) st++;
        start_i = (poke && n == 5);
      end
    end
    start_i = 1'b0;
    chk("valid_seen", {63'd0, seen}, 64'd1);
    chk("latency", 64'(n), (b == 32'd0) ? 64'd1 : 64'd33);
    chk("busy_stall", 64'(st), (b == 32'd0) ? 64'd0 : 64'd32);
    chk("stall_done", {63'd0, stall_at_valid}, 64'd0);
    @(negedge clk);
    chk("valid_pulse", {63'd0, valid_o}, 64'd0);
    chk("result_hold", result_o, exp);
  endtask

  logic [31:0] ra, rb;
  logic        rs;

  initial begin
    resetn = 1'b0; start_i = 1'b0; signed_i = 1'b0; cancel_i = 1'b0;
    a_i = '0; b_i = '0;
    repeat (3) @(negedge clk);
    chk("reset_stall", {63'd0, stall_o}, 64'd0);
    chk("reset_valid", {63'd0, valid_o}, 64'd0);
    chk("reset_result", result_o, 64'd0);
    resetn = 1'b1;

    // Directed cases
    do_div(32'd100, 32'd7, 1'b0, 0);
    chk("divu_100_7", result_o, {32'd2, 32'd14});
    do_div(32'hFFFF_FFF9, 32'd2, 1'b1, 0);
    chk("div_m7_2", result_o, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    do_div(32'd7, 32'hFFFF_FFFE, 1'b1, 0);
    chk("div_7_m2", result_o, {32'h0000_0001, 32'hFFFF_FFFD});
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
    chk("div_ovf", result_o, {32'h0, 32'h8000_0000});
    do_div(32'hFFFF_FFFF, 32'd1, 1'b0, 0);
    chk("divu_max_1", result_o, {32'h0, 32'hFFFF_FFFF});
    do_div(32'd123, 32'd0, 1'b1, 0);
    do_div(32'hDEAD_BEEF, 32'd0, 1'b0, 0);
    do_div(32'h8000_0000, 32'd3, 1'b1, 0);

    // Start while busy is ignored
    do_div(32'd5000, 32'd13, 1'b0, 1);

    // Cancel in BUSY: no result, then a new start one cycle later
    @(negedge clk);
    a_i = 32'd100; b_i = 32'd7; signed_i = 1'b0; start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    repeat (10) @(negedge clk);
    cancel_i = 1'b1;
    @(posedge clk);
    #1 cancel_i = 1'b0;
    @(negedge clk);
    chk("cancel_stall", {63'd0, stall_o}, 64'd0);
    chk("cancel_valid", {63'd0, valid_o}, 64'd0);
    do_div(32'd1000, 32'd9, 1'b0, 0);

    // Cancel in DONE suppresses the pulse
    @(negedge clk);
    a_i = 32'd55; b_i = 32'd0; signed_i = 1'b0; start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0; cancel_i = 1'b1;
    #1 chk("cancel_done_valid", {63'd0, valid_o}, 64'd0);
    @(posedge clk);
    #1 cancel_i = 1'b0;

    // Asynchronous reset mid-operation
    do_div(32'd77777, 32'd5, 1'b0, 0);
    @(negedge clk);
    a_i = 32'd1234; b_i = 32'd5; signed_i = 1'b0; start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    repeat (5) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("arst_stall", {63'd0, stall_o}, 64'd0);
    chk("arst_valid", {63'd0, valid_o}, 64'd0);
    chk("arst_result", result_o, 64'd0);
    repeat (2) @(negedge clk);
    chk("arst_hold", result_o, 64'd0);
    resetn = 1'b1;
    do_div(32'hFFFF_FF00, 32'd16, 1'b1, 0);

    // Randomized operands
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      if ($urandom_range(0, 3) == 0) ra = $urandom_range(0, 200);
      case ($urandom_range(0, 3))
        0:       rb = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'hFFFF_FFFF;
        1:       rb = $urandom_range(1, 15);
        default: rb = $urandom;
      endcase
      rs = 1'($urandom_range(0, 1));
      do_div(ra, rb, rs, ($urandom_range(0, 4) == 0));
    end

    repeat (5) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
